// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Turns single commands (read/write, byte address, write data) into one
//   strobed access on a simple memory bus and returns a one-cycle response.
//   FSM: IDLE -> ACCESS -> DONE -> IDLE. A misaligned command (addr[1:0] != 0)
//   skips ACCESS and goes straight to DONE with an error response.
//
// Optional feature (macro MEM_BUS_MASTER_TIMEOUT_EN):
//   aborts ACCESS after TIMEOUT_CYCLES cycles without ACK, error response.
//   Without the macro no counter is built and ACCESS waits for ACK forever.
//
// Ports
//   MEM_BUS_MASTER_CLOCK_50          clock, rising edge
//   MEM_BUS_MASTER_ResetInHigh_In    synchronous active-high reset
//   MEM_BUS_MASTER_Cmd*              command channel (valid/ready handshake)
//   MEM_BUS_MASTER_Rsp*              response: valid pulse, read data, error
//   MEM_BUS_MASTER_A_OutBus/B_OutBus memory address / write data
//   MEM_BUS_MASTER_RD_Out/WRMain_Out memory read / write strobes
//   MEM_BUS_MASTER_ACK_In/Data_InBus memory acknowledge / read data
module mem_bus_master #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     MEM_BUS_MASTER_CLOCK_50,
  input  logic                     MEM_BUS_MASTER_ResetInHigh_In,
  input  logic                     MEM_BUS_MASTER_CmdValid_In,
  output logic                     MEM_BUS_MASTER_CmdReady_Out,
  input  logic                     MEM_BUS_MASTER_CmdWrite_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_CmdAddr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_CmdWData_InBus,
  output logic                     MEM_BUS_MASTER_RspValid_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_RspRData_OutBus,
  output logic                     MEM_BUS_MASTER_RspError_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_A_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_B_OutBus,
  output logic                     MEM_BUS_MASTER_RD_Out,
  output logic                     MEM_BUS_MASTER_WRMain_Out,
  input  logic                     MEM_BUS_MASTER_ACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_BUS_MASTER_Data_InBus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic                     wr_q, wr_d;
  logic [DATAWIDTH_BUS-1:0] a_q, a_d;
  logic [DATAWIDTH_BUS-1:0] b_q, b_d;
  logic                     rd_stb_q, rd_stb_d;
  logic                     wr_stb_q, wr_stb_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [DATAWIDTH_BUS-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    wr_d        = wr_q;
    a_d         = a_q;
    b_d         = b_q;
    rd_stb_d    = rd_stb_q;
    wr_stb_d    = wr_stb_q;
    // Response fields are only meaningful for the single DONE cycle.
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    cnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (MEM_BUS_MASTER_CmdValid_In && ready_q) begin
          ready_d = 1'b0;
          wr_d    = MEM_BUS_MASTER_CmdWrite_In;
          a_d     = MEM_BUS_MASTER_CmdAddr_InBus;
          b_d     = MEM_BUS_MASTER_CmdWData_InBus;
          if (MEM_BUS_MASTER_CmdAddr_InBus[1:0] != 2'b00) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            rd_stb_d = !MEM_BUS_MASTER_CmdWrite_In;
            wr_stb_d = MEM_BUS_MASTER_CmdWrite_In;
          end
        end
      end
      ACCESS: begin
        // ACK is checked first so it wins over a timeout in the same cycle.
        if (MEM_BUS_MASTER_ACK_In) begin
          state_d     = DONE;
          rd_stb_d    = 1'b0;
          wr_stb_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? '0 : MEM_BUS_MASTER_Data_InBus;
        end
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
            state_d     = DONE;
            rd_stb_d    = 1'b0;
            wr_stb_d    = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d  = IDLE;
        ready_d  = 1'b1;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MEM_BUS_MASTER_CLOCK_50) begin
    if (MEM_BUS_MASTER_ResetInHigh_In) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      wr_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef MEM_BUS_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign MEM_BUS_MASTER_CmdReady_Out    = ready_q;
  assign MEM_BUS_MASTER_RspValid_Out    = rsp_valid_q;
  assign MEM_BUS_MASTER_RspRData_OutBus = rsp_rdata_q;
  assign MEM_BUS_MASTER_RspError_Out    = rsp_err_q;
  assign MEM_BUS_MASTER_A_OutBus        = a_q;
  assign MEM_BUS_MASTER_B_OutBus        = b_q;
  assign MEM_BUS_MASTER_RD_Out          = rd_stb_q;
  assign MEM_BUS_MASTER_WRMain_Out      = wr_stb_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master
//   Directed bench for mem_bus_master: reset state, read/write/misaligned
//   commands, stray ACK, reset mid-access, timeout (or indefinite wait when
//   the timeout macro is off) and back-to-back commands.
module tb_mem_bus_master;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [DW-1:0] a_out, b_out;
  logic          rd_o, wr_o;
  logic          ack = 1'b0;
  logic [DW-1:0] mem_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_master #(.DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(16)) dut (
    .MEM_BUS_MASTER_CLOCK_50        (clk),
    .MEM_BUS_MASTER_ResetInHigh_In  (rst),
    .MEM_BUS_MASTER_CmdValid_In     (cmd_valid),
    .MEM_BUS_MASTER_CmdReady_Out    (cmd_ready),
    .MEM_BUS_MASTER_CmdWrite_In     (cmd_write),
    .MEM_BUS_MASTER_CmdAddr_InBus   (cmd_addr),
    .MEM_BUS_MASTER_CmdWData_InBus  (cmd_wdata),
    .MEM_BUS_MASTER_RspValid_Out    (rsp_valid),
    .MEM_BUS_MASTER_RspRData_OutBus (rsp_rdata),
    .MEM_BUS_MASTER_RspError_Out    (rsp_err),
    .MEM_BUS_MASTER_A_OutBus        (a_out),
    .MEM_BUS_MASTER_B_OutBus        (b_out),
    .MEM_BUS_MASTER_RD_Out          (rd_o),
    .MEM_BUS_MASTER_WRMain_Out      (wr_o),
    .MEM_BUS_MASTER_ACK_In          (ack),
    .MEM_BUS_MASTER_Data_InBus      (mem_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Outputs are sampled and inputs changed 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command: ACK given in the dly-th strobe cycle (dly=0: misaligned,
  // no ACCESS phase at all). Checks strobe count, bus stability, response.
  task automatic txn(input string tg, input logic wr, input logic [DW-1:0] addr,
                     input logic [DW-1:0] wd, input logic [DW-1:0] md, input int dly,
                     input logic [DW-1:0] exp_rd, input logic exp_err);
    int rd_n, wr_n, bad;
    rd_n = 0; wr_n = 0; bad = 0;
    chk({tg, "_ready"}, {31'd0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
    for (int k = 1; k <= dly; k++) begin
      rd_n += int'(rd_o);
      wr_n += int'(wr_o);
      if (a_out !== addr || (wr && b_out !== wd) || rsp_valid || cmd_ready) bad++;
      ack      = (k == dly);
      mem_data = (k == dly) ? md : 32'hA5A5_A5A5;
      step();
    end
    ack = 1'b0;
    chk({tg, "_rd_cycles"}, rd_n, (!wr && dly > 0) ? dly : 0);
    chk({tg, "_wr_cycles"}, wr_n, (wr && dly > 0) ? dly : 0);
    chk({tg, "_bus_stable"}, bad, 0);
    chk({tg, "_strobe_off"}, {30'd0, rd_o, wr_o}, 0);
    chk({tg, "_rsp_valid"}, {31'd0, rsp_valid}, 1);
    chk({tg, "_rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tg, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    step();
    chk({tg, "_rsp_pulse"}, {31'd0, rsp_valid}, 0);
    chk({tg, "_ready_back"}, {31'd0, cmd_ready}, 1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    rst = 1'b1;
    step(); step();
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_strobes", {30'd0, rd_o, wr_o}, 0);
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    rst = 1'b0;
    step();

    // ---------------- basic transactions ----------------
    txn("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1'b0);
    txn("wr20", 1'b1, 32'h20, 32'h1234_5678, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
    chk("wr20_b_held", b_out, 32'h1234_5678);
    txn("mis3", 1'b0, 32'h3, 32'h0, 32'h0, 0, 32'h0, 1'b1);
    txn("mis_wr", 1'b1, 32'h22, 32'hCAFE_F00D, 32'h0, 0, 32'h0, 1'b1);

    // ---------------- stray ACK in IDLE ----------------
    ack = 1'b1; mem_data = 32'h5555_AAAA;
    step(); step();
    ack = 1'b0;
    chk("stray_idle_ready", {31'd0, cmd_ready}, 1);
    chk("stray_idle_rsp", {30'd0, rsp_valid, rsp_err}, 0);
    chk("stray_idle_strobe", {30'd0, rd_o, wr_o}, 0);

`ifdef MEM_BUS_MASTER_TIMEOUT_EN
    // ---------------- timeout: no ACK ----------------
    begin
      int rd_n, n;
      rd_n = 0; n = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
      step();
      cmd_valid = 1'b0;
      while (!rsp_valid && n < 40) begin
        rd_n += int'(rd_o);
        n++;
        step();
      end
      chk("tmo_rd_cycles", rd_n, 16);
      chk("tmo_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("tmo_rsp_err", {31'd0, rsp_err}, 1);
      chk("tmo_rdata", rsp_rdata, 0);
      ack = 1'b1; mem_data = 32'h1111_2222;
      step();
      ack = 1'b0;
      chk("tmo_stray_ready", {31'd0, cmd_ready}, 1);
      chk("tmo_stray_rsp", {31'd0, rsp_valid}, 0);
      chk("tmo_stray_rd", {31'd0, rd_o}, 0);
    end
    // ACK landing in the 16th cycle completes normally
    txn("tmo_ack_wins", 1'b0, 32'h44, 32'h0, 32'h7777_0001, 16, 32'h7777_0001, 1'b0);
`else
    // Without the timeout, a long wait still completes normally.
    txn("long_wait", 1'b0, 32'h44, 32'h0, 32'h7777_0001, 20, 32'h7777_0001, 1'b0);
`endif

    // ---------------- reset in 2nd ACCESS cycle ----------------
    begin
      int spur;
      spur = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
      step();
      cmd_valid = 1'b0;
      step();
      chk("rstacc_rd_before", {31'd0, rd_o}, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstacc_rd", {31'd0, rd_o}, 0);
      chk("rstacc_ready", {31'd0, cmd_ready}, 1);
      chk("rstacc_a", a_out, 0);
      for (int k = 0; k < 3; k++) begin
        spur += int'(rsp_valid);
        step();
      end
      chk("rstacc_no_rsp", spur, 0);
      txn("after_rst", 1'b0, 32'h54, 32'h0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0);
    end

    // ---------------- back-to-back, CmdValid held ----------------
    // The memory ACKs in the first strobe cycle; read data = addr ^ key.
    begin
      logic [DW-1:0] exp_q[$];
      int last_acc, n_rsp, idx, bad_acc;
      logic accepted;
      last_acc = -1; n_rsp = 0; idx = 0; bad_acc = 0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h100;
      for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
        if (rsp_valid) begin
          if (exp_q.size() == 0) chk("b2b_unexpected_rsp", rsp_rdata, 32'hFFFF_FFFF);
          else chk("b2b_rdata", rsp_rdata, exp_q.pop_front());
          n_rsp++;
        end
        accepted = cmd_valid && cmd_ready;
        if (accepted) begin
          exp_q.push_back(cmd_addr ^ 32'hCAFE_0000);
          // Acceptance edges three apart: IDLE, ACCESS, DONE, then the next
          // IDLE is the fourth cycle of the window and accepts again.
          if (last_acc >= 0) chk("b2b_period", cyc - last_acc, 3);
          last_acc = cyc;
          idx++;
        end
        if (!cmd_ready && (rd_o === 1'b0) && !rsp_valid) bad_acc++;
        ack      = rd_o;
        mem_data = a_out ^ 32'hCAFE_0000;
        step();
        if (accepted) begin
          cmd_addr = 32'h100 + 32'(4 * idx);
          if (idx == 4) cmd_valid = 1'b0;
        end
      end
      ack = 1'b0;
      cmd_valid = 1'b0;
      chk("b2b_rsp_count", n_rsp, 4);
      chk("b2b_ready_only_idle", bad_acc, 0);
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
